// File: rtl/gpio_led_fader.sv
// gpio_led_fader
// Per-channel LED PWM fader that sits between the Nios II GPIO export and
// the board LED pins. Each GPIO bit requests its channel fully on or fully
// off; the channel's duty cycle either snaps to that target or ramps toward
// it in fixed steps. Duty changes are applied only at the end of a PWM
// period, so no period is ever cut short and the LEDs never glitch.
//
// Ports:
//   clk_clk        in   1  system clock (single clock domain)
//   reset_reset_n  in   1  asynchronous active-low reset
//   gpio_in        in   8  channel requests, bit i = 1 -> channel i fully on
//   fade_en        in   1  1 = ramp duty in STEP increments, 0 = snap to target
//   led_out        out  8  registered PWM drive, polarity set by INVERT
//   busy           out  1  high while any channel's duty differs from its target
//   period_strobe  out  1  one-cycle pulse at the start of each PWM period
module gpio_led_fader #(
    parameter int unsigned PRESCALE = 16,
    parameter int unsigned FADE_DIV = 4,
    parameter int unsigned STEP     = 15,
    parameter logic [7:0]  INVERT   = 8'h00
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [7:0] gpio_in,
    input  logic       fade_en,
    output logic [7:0] led_out,
    output logic       busy,
    output logic       period_strobe
);

    // Counter widths are kept at least one bit so PRESCALE = 1 or
    // FADE_DIV = 1 still elaborate; the counter then simply stays at zero.
    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PRESCALE - 1);
    localparam logic [FADE_W-1:0] FADE_MAX = FADE_W'(FADE_DIV - 1);
    localparam logic [8:0]        STEP9    = 9'(STEP);

    logic [7:0]        gpio_q;
    logic [PRE_W-1:0]  pre_cnt;
    logic [7:0]        pwm_cnt;
    logic [FADE_W-1:0] fade_cnt;
    logic [7:0]        duty   [8];
    logic [7:0]        target [8];
    logic [7:0]        raw;
    logic              any_diff;
    logic              tick;
    logic              wrap;
    logic              fstep;

    // One fade step of a single channel. The distance is taken in 9 bits so
    // neither direction can wrap; a move that would cross the target lands
    // exactly on it instead.
    function automatic logic [7:0] fade_step(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] cur9;
        logic [8:0] tgt9;
        logic [7:0] result;
        cur9   = {1'b0, cur};
        tgt9   = {1'b0, tgt};
        result = cur;
        if (tgt9 > cur9) begin
            if ((tgt9 - cur9) <= STEP9) result = tgt;
            else                        result = 8'(cur9 + STEP9);
        end else if (cur9 > tgt9) begin
            if ((cur9 - tgt9) <= STEP9) result = tgt;
            else                        result = 8'(cur9 - STEP9);
        end
        return result;
    endfunction

    // Period boundaries: tick advances the PWM counter, wrap marks the last
    // clock of a PWM period, fstep marks the wraps on which a fade step lands.
    assign tick  = (pre_cnt == PRE_MAX);
    assign wrap  = tick && (pwm_cnt == 8'hFF);
    assign fstep = wrap && (fade_cnt == FADE_MAX);

    // Per-channel target level, raw PWM compare and the "still moving" flag.
    // Duty 255 is forced fully on because the 8-bit compare alone would leave
    // one count per period dark.
    always_comb begin
        raw      = '0;
        any_diff = 1'b0;
        for (int i = 0; i < 8; i++) begin
            target[i] = gpio_q[i] ? 8'hFF : 8'h00;
            raw[i]    = (duty[i] == 8'hFF) || (pwm_cnt < duty[i]);
            if (duty[i] != target[i]) any_diff = 1'b1;
        end
    end

    // Input register and the prescaler / PWM / fade counter chain.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            gpio_q   <= '0;
            pre_cnt  <= '0;
            pwm_cnt  <= '0;
            fade_cnt <= '0;
        end else begin
            gpio_q  <= gpio_in;
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 8'd1;
            if (wrap) fade_cnt <= fstep ? '0 : fade_cnt + 1'b1;
        end
    end

    // Duty registers only move on a period boundary. fade_en is looked at
    // only here, so switching modes mid-period has no visible effect until
    // the next wrap.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < 8; i++) duty[i] <= 8'h00;
        end else if (wrap) begin
            for (int i = 0; i < 8; i++) begin
                if (!fade_en)  duty[i] <= target[i];
                else if (fstep) duty[i] <= fade_step(duty[i], target[i]);
            end
        end
    end

    // Registered outputs so the LED pins see clean, glitch-free edges.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            led_out       <= INVERT;
            busy          <= 1'b0;
            period_strobe <= 1'b0;
        end else begin
            led_out       <= raw ^ INVERT;
            busy          <= any_diff;
            period_strobe <= wrap;
        end
    end

endmodule

// File: tb/tb_gpio_led_fader.sv
// Testbench for gpio_led_fader.
// Two instances share all inputs: u_dut with normal polarity and u_inv with
// every channel inverted. A period-level reference of the duty registers
// predicts the PWM high time per period; expectations are queued when a
// period starts and compared once the DUT has produced that period.
module tb_gpio_led_fader;

    localparam int PRESCALE = 2;
    localparam int FADE_DIV = 2;
    localparam int STEP     = 15;
    localparam int PERIOD   = 256 * PRESCALE;

    logic       clk_clk       = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic [7:0] gpio_in       = 8'h00;
    logic       fade_en       = 1'b0;
    logic [7:0] led_out;
    logic       busy;
    logic       period_strobe;
    logic [7:0] led_inv;
    logic       busy_inv;
    logic       strobe_inv;

    typedef struct {
        logic [7:0] gpio;
        logic [7:0] led;
        logic [7:0] inv_led;
    } vec_t;

    typedef struct {
        int         hi;
        logic       busy;
        logic [7:0] led;
        logic [7:0] inv_led;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[4];
    int   exp_duty[8];
    logic model_busy;
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    gpio_led_fader #(.PRESCALE(PRESCALE), .FADE_DIV(FADE_DIV), .STEP(STEP), .INVERT(8'h00)) u_dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .gpio_in(gpio_in), .fade_en(fade_en),
        .led_out(led_out), .busy(busy), .period_strobe(period_strobe)
    );

    gpio_led_fader #(.PRESCALE(PRESCALE), .FADE_DIV(FADE_DIV), .STEP(STEP), .INVERT(8'hFF)) u_inv (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .gpio_in(gpio_in), .fade_en(fade_en),
        .led_out(led_inv), .busy(busy_inv), .period_strobe(strobe_inv)
    );

    always #5 clk_clk = ~clk_clk;

    // Clocks since reset release; a wrap lands on every multiple of PERIOD.
    always @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) cyc <= 0;
        else                cyc <= cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_value(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    // Period-level reference: applies the duty update of the wrap that has
    // just occurred, using the inputs that were stable across that wrap.
    task automatic model_wrap();
        int m;
        int tgt;
        m = cyc / PERIOD;
        model_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tgt = gpio_in[i] ? 255 : 0;
            if (!fade_en) begin
                exp_duty[i] = tgt;
            end else if (m % FADE_DIV == 0) begin
                if (tgt > exp_duty[i])
                    exp_duty[i] = (tgt - exp_duty[i] <= STEP) ? tgt : exp_duty[i] + STEP;
                else if (exp_duty[i] > tgt)
                    exp_duty[i] = (exp_duty[i] - tgt <= STEP) ? tgt : exp_duty[i] - STEP;
            end
            if (exp_duty[i] != tgt) model_busy = 1'b1;
        end
    endtask

    // Advance to the sample just after the next wrap edge.
    task automatic wait_wrap();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (cyc % PERIOD != 0 && n < 2 * PERIOD);
        if (cyc % PERIOD != 0) check_value("wrap_timeout", cyc % PERIOD, 0);
        else                   model_wrap();
    endtask

    task automatic wait_mod(input int r);
        int n;
        n = 0;
        while (cyc % PERIOD != r && n < 2 * PERIOD) begin
            step();
            n++;
        end
        if (cyc % PERIOD != r) check_value("align_timeout", cyc % PERIOD, r);
    endtask

    // Measure one whole PWM period of channel ch, starting right after a wrap.
    task automatic run_period(input int ch, input string name);
        exp_t e;
        int   hi;
        int   inv_bad;
        int   strobes;
        logic b;
        hi      = 0;
        inv_bad = 0;
        strobes = 0;
        b       = 1'b0;
        e.hi      = (exp_duty[ch] == 255) ? PERIOD : exp_duty[ch] * PRESCALE;
        e.busy    = model_busy;
        e.led     = 8'h00;
        e.inv_led = 8'h00;
        sb.push_back(e);
        for (int k = 0; k < PERIOD; k++) begin
            step();
            if (k == 0) b = busy;
            hi += int'(led_out[ch]);
            if (led_inv !== ~led_out) inv_bad++;
            strobes += int'(period_strobe);
        end
        e = sb.pop_front();
        check_value($sformatf("%s_high_clocks_ch%0d", name, ch), hi, e.hi);
        check_value($sformatf("%s_busy", name), int'(b), int'(e.busy));
        check_value($sformatf("%s_inverted_copy", name), inv_bad, 0);
        check_value($sformatf("%s_strobe_count", name), strobes, 1);
        model_wrap();
    endtask

    task automatic apply_stimulus(input vec_t v);
        exp_t e;
        gpio_in   = v.gpio;
        fade_en   = 1'b0;
        e.hi      = 0;
        e.busy    = 1'b0;
        e.led     = v.led;
        e.inv_led = v.inv_led;
        sb.push_back(e);
    endtask

    task automatic check_output(input int idx);
        exp_t e;
        e = sb.pop_front();
        check_value($sformatf("vec%0d_led", idx), int'(led_out), int'(e.led));
        check_value($sformatf("vec%0d_led_inv", idx), int'(led_inv), int'(e.inv_led));
        check_value($sformatf("vec%0d_busy", idx), int'(busy), int'(e.busy));
    endtask

    initial begin
        int first_strobe;
        int strobe_bad;
        int extra;

        vecs[0] = '{gpio: 8'h0F, led: 8'h0F, inv_led: 8'hF0};
        vecs[1] = '{gpio: 8'hA5, led: 8'hA5, inv_led: 8'h5A};
        vecs[2] = '{gpio: 8'hFF, led: 8'hFF, inv_led: 8'h00};
        vecs[3] = '{gpio: 8'h00, led: 8'h00, inv_led: 8'hFF};
        for (int i = 0; i < 8; i++) exp_duty[i] = 0;
        model_busy = 1'b0;

        // Reset state.
        repeat (3) step();
        check_value("reset_led", int'(led_out), 8'h00);
        check_value("reset_led_inv", int'(led_inv), 8'hFF);
        check_value("reset_busy", int'(busy), 0);
        check_value("reset_strobe", int'(period_strobe), 0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;

        // Strobe cadence: first pulse after exactly one period, then periodic.
        $display("[TB] strobe cadence");
        first_strobe = -1;
        strobe_bad   = 0;
        for (int k = 0; k < 1100; k++) begin
            step();
            if (period_strobe !== (cyc % PERIOD == 0)) strobe_bad++;
            if (period_strobe === 1'b1 && first_strobe < 0) first_strobe = cyc;
        end
        check_value("strobe_first_cycle", first_strobe, PERIOD);
        check_value("strobe_pattern_errors", strobe_bad, 0);
        check_value("idle_led", int'(led_out), 8'h00);

        // Snap mode: busy latency, then duty lands at the next wrap.
        $display("[TB] snap mode, single channel");
        wait_mod(100);
        gpio_in = 8'h01;
        step();
        check_value("busy_after_1_clock", int'(busy), 0);
        step();
        check_value("busy_after_2_clocks", int'(busy), 1);
        wait_wrap();
        check_value("led_at_wrap", int'(led_out), 8'h00);
        check_value("busy_at_wrap", int'(busy), 1);
        step();
        check_value("led_after_wrap", int'(led_out), 8'h01);
        check_value("led_inv_after_wrap", int'(led_inv), 8'hFE);
        check_value("busy_after_wrap", int'(busy), 0);

        // Snap mode vectors.
        $display("[TB] snap mode vectors");
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(vecs[i]);
            wait_wrap();
            step();
            check_output(i);
        end

        // Full ramp up of channel 7.
        $display("[TB] fade up channel 7");
        fade_en = 1'b1;
        gpio_in = 8'h80;
        wait_wrap();
        extra = 0;
        for (int p = 0; p < 45 && extra < 2; p++) begin
            run_period(7, "ramp_up");
            if (exp_duty[7] == 255) extra++;
        end
        check_value("busy_after_ramp", int'(busy), 0);

        // Reversal of channel 3 mid-ramp.
        $display("[TB] fade reversal channel 3");
        gpio_in = 8'h88;
        for (int p = 0; p < 30 && exp_duty[3] != 90; p++) run_period(3, "rev_up");
        gpio_in = 8'h80;
        for (int p = 0; p < 30 && exp_duty[3] != 0; p++) run_period(3, "rev_down");
        run_period(3, "rev_settle");
        run_period(3, "rev_settle");
        check_value("busy_after_reversal", int'(busy), 0);

        // Asynchronous reset in the middle of a fade.
        $display("[TB] reset mid-fade");
        gpio_in = 8'h01;
        repeat (3) run_period(0, "pre_reset");
        @(posedge clk_clk);
        #3;
        reset_reset_n = 1'b0;
        #1;
        check_value("async_reset_led", int'(led_out), 8'h00);
        check_value("async_reset_led_inv", int'(led_inv), 8'hFF);
        check_value("async_reset_busy", int'(busy), 0);
        check_value("async_reset_strobe", int'(period_strobe), 0);
        for (int i = 0; i < 8; i++) exp_duty[i] = 0;
        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        wait_wrap();
        repeat (4) run_period(0, "restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_led_fader.md
# gpio_led_fader

Per-channel LED PWM fader driven by the 8-bit GPIO output word of the Nios II system. Each GPIO bit is a channel on/off request. The block ramps that channel's duty cycle toward fully on or fully off and emits glitch-free PWM to the board LEDs. It sits between the processor's GPIO export and the FPGA LED pins.

## Interface
Parameters:
- PRESCALE, 16: clocks per PWM count tick; must be ≥ 1.
- FADE_DIV, 4: PWM periods per fade step; must be ≥ 1.
- STEP, 15: duty increment/decrement per fade step, in the range 1..255.
- INVERT, 8'h00: per-channel output polarity mask; a 1 bit gives an active-low LED.

Ports:
- clk_clk  in  1  system clock. All logic is in this single clock domain.
- reset_reset_n  in  1  asynchronous, active-low reset.
- gpio_in  in  8  channel request; bit i = 1 requests channel i fully on. Connects to gpioa_export.
- fade_en  in  1  1 = ramp duty, 0 = snap duty to target.
- led_out  out  8  PWM LED drive, after the INVERT mask is applied.
- busy  out  1  high while any channel's duty differs from its target.
- period_strobe  out  1  one-cycle pulse at the start of each PWM period.

## Operation
- gpio_q: registered copy of gpio_in, updated every clock.
- target[i] = gpio_q[i] ? 255 : 0.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and then wraps.
  - tick is asserted when pre_cnt == PRESCALE-1.
- PWM counter:
  - pwm_cnt (8 bits) increments on tick and wraps 255→0.
  - wrap is defined as tick && pwm_cnt == 255.
  - PWM period = 256·PRESCALE clocks.
- Fade counter:
  - fade_cnt counts wraps 0..FADE_DIV-1.
  - fstep is defined as wrap && fade_cnt == FADE_DIV-1.
- Duty registers duty[i] (8 bits) change only on a wrap edge, so no PWM period is ever truncated:
  - fade_en = 0: duty[i] ← target[i] on every wrap.
  - fade_en = 1, on fstep:
    - If |target[i] − duty[i]| ≤ STEP, then duty[i] ← target[i].
    - Otherwise duty[i] moves toward target[i] by STEP.
    - duty never overshoots and never under/overflows (computed with 9-bit arithmetic).
  - fade_en is sampled only at the wrap edge.
- Raw PWM: raw[i] = (duty[i] == 255) || (pwm_cnt < duty[i]).
  - duty 0 is constantly off.
  - duty 255 is constantly on.
  - Otherwise raw[i] is high for duty·PRESCALE clocks per period.
- Registered outputs:
  - led_out[i] ← raw[i] ^ INVERT[i].
  - busy ← OR over i of (duty[i] != target[i]).
  - period_strobe ← wrap.
- A target reversal mid-fade is legal: the ramp reverses from the current duty at the next fstep.

## Timing
- Reset (asynchronous assert, synchronous-clean deassert):
  - gpio_q, pre_cnt, pwm_cnt, fade_cnt and all duty registers are cleared to 0.
  - led_out = INVERT, busy = 0, period_strobe = 0.
- First wrap occurs 256·PRESCALE clocks after reset release.
- period_strobe is high in the first cycle with pwm_cnt == 0 after each wrap. It is never asserted for the initial reset state.
- gpio_in → gpio_q takes 1 clock. busy reflects a changed target 2 clocks after gpio_in changes (via gpio_q, then the busy register).
- duty → led_out takes 1 clock, registered.
- Worst-case request-to-LED latency with fade_en = 0: 1 PWM period + 3 clocks.
- Full ramp with fade_en = 1: ceil(255/STEP)·FADE_DIV periods. Default is 17·4 = 68 periods.
- Reset asserted mid-fade: all state is cleared immediately. There is no resume; fading restarts from duty 0.

## Test plan
Use PRESCALE=2, FADE_DIV=2, STEP=15, INVERT=8'h00 unless stated. PWM period = 512 clocks.

1. Reset release, gpio_in=0 → led_out=0, busy=0. No period_strobe for the first 512 clocks; single-cycle strobe at clock 513; then strobe every 512 clocks.
2. fade_en=0, gpio_in=8'h01 → busy goes high 2 clocks later; at the next wrap duty0=255; led_out = 8'h01 constant from wrap+1; busy drops.
3. fade_en=1, gpio_in 8'h00→8'h80 → duty7 = 15, 30, …, 255, one step every 2 periods:
   - at duty 30, led_out[7] is high for exactly 60 clocks per period;
   - 255 is reached after 34 periods, then led_out[7] is constant 1 and busy=0.
4. Reversal: ramp bit 3 up to duty 90, then clear gpio_in[3] → next steps are 75, 60, …, 0; led_out[3] is constant 0 and busy=0 after 12 periods.
5. INVERT=8'hFF, gpio_in=8'h0F, fade_en=0 → after reset, led_out=8'hFF; after the first wrap, led_out=8'hF0 constant.
6. Assert reset_reset_n=0 mid-fade, asynchronous between clock edges → led_out=INVERT and busy=0 within the same cycle; after release, the ramp restarts from 15 at the first fstep.
